hci_prio_scheduler: RTL and testbench
=====================================

# hci_prio_scheduler

Runtime arbitration controller for the cluster TCDM heterogeneous interconnect. It observes core-side and HWPE-side request/grant activity and drives the interconnect control word (arbitration policy, priority inversion, low-priority stall budget). It prevents starvation of whichever side currently has low priority by switching priority on programmable stall thresholds. Software configures it through a peripheral-bus slave port.

## Interface
- NB_CORES, 8: core TCDM ports observed.
- NB_HWPE, 1: HWPE TCDM ports observed; must be at least 1.
- STALL_CNT_W, 8: width of stall counters and thresholds.
- WINDOW_W, 16: width of the priority-window counter.
- ID_WIDTH, 5: peripheral-bus transaction ID width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- core_req_i  in  NB_CORES  core TCDM request per port.
- core_gnt_i  in  NB_CORES  core TCDM grant per port.
- hwpe_req_i  in  NB_HWPE  HWPE TCDM request.
- hwpe_gnt_i  in  NB_HWPE  HWPE TCDM grant.
- cfg_req_i  in  1  config request.
- cfg_add_i  in  32  byte address; only bits [4:2] are decoded.
- cfg_wen_i  in  1  1 = read, 0 = write.
- cfg_wdata_i  in  32  write data.
- cfg_be_i  in  4  byte enables.
- cfg_id_i  in  ID_WIDTH  transaction ID.
- cfg_gnt_o  out  1  grant.
- cfg_r_valid_o  out  1  response valid.
- cfg_r_rdata_o  out  32  read data.
- cfg_r_opc_o  out  1  error flag.
- cfg_r_id_o  out  ID_WIDTH  response ID.
- arb_policy_o  out  2  to hci_interconnect_ctrl_t.arb_policy.
- invert_prio_o  out  1  to hci_interconnect_ctrl_t.invert_prio; 1 = HWPE side wins.
- low_prio_max_stall_o  out  8  to hci_interconnect_ctrl_t.low_prio_max_stall.

## Operation
Register map (word index = add[4:2]):
- 0 CTRL: bit0 auto_en; bit1 static_invert; bits[3:2] arb_policy; bits[11:4] low_prio_max_stall. Reset 0.
- 1 HWPE_THR: threshold for HWPE stalls. Reset 8.
- 2 CORE_THR: threshold for core stalls. Reset 8.
- 3 WINDOW: length of the HWPE-priority window in cycles. Reset 64.
- 4 STATUS (RO): bit0 current state (1 = HWPE_PRIO); bits[15:8] hwpe_stall_cnt; bits[23:16] core_stall_cnt.
- 5 SWITCH_CNT (RO): 32-bit saturating count of CORE_PRIO->HWPE_PRIO transitions. Any write clears it.
- Indices 6-7: reads return 0; writes are ignored; cfg_r_opc_o = 1.
- Writes honour cfg_be_i per byte. Writes to RO registers set cfg_r_opc_o = 1, except the clear action on index 5.

Stall events:
- hwpe_stall = OR over ports of (hwpe_req_i & ~hwpe_gnt_i).
- core_stall = OR over ports of (core_req_i & ~core_gnt_i).

FSM, active only when auto_en = 1; otherwise the FSM is forced to CORE_PRIO and both counters are held at 0.
- CORE_PRIO: invert_prio_o = 0.
  - hwpe_stall_cnt increments (saturating) on each hwpe_stall cycle.
  - It clears on any cycle with an HWPE grant and no hwpe_stall.
  - When the incremented value is >= HWPE_THR: go to HWPE_PRIO, load win_cnt = WINDOW, clear hwpe_stall_cnt, and increment SWITCH_CNT.
- HWPE_PRIO: invert_prio_o = 1.
  - win_cnt decrements every cycle.
  - core_stall_cnt counts like hwpe_stall_cnt, using core_stall.
  - Exit to CORE_PRIO when win_cnt reaches 0 or core_stall_cnt reaches >= CORE_THR, whichever comes first; clear both counters on exit.
- A threshold of 0 behaves as 1.
- WINDOW = 0 gives a 1-cycle window.

Outputs:
- invert_prio_o = auto_en ? (state == HWPE_PRIO) : static_invert.
- arb_policy_o and low_prio_max_stall_o are driven directly from CTRL.

## Timing
- All outputs are registered except cfg_gnt_o, which equals cfg_req_i combinationally.
- cfg_r_valid_o, cfg_r_rdata_o, cfg_r_id_o and cfg_r_opc_o are valid exactly 1 cycle after the granted request; there is no backpressure.
- invert_prio_o changes in the cycle after the threshold-crossing stall cycle (1-cycle latency).
- A CTRL write takes effect on the outputs in the cycle after the write is granted.
- Clearing auto_en while in HWPE_PRIO returns to CORE_PRIO on the next edge.
- A config write and a state transition in the same cycle: the FSM uses the old threshold values; the new values apply from the next cycle.
- A SWITCH_CNT clear and an increment in the same cycle: the result is 0.
- Counters saturate at all-ones and never wrap.
- Reset values:
  - Outputs: all 0.
  - State: CORE_PRIO.
  - Counters: 0.
  - Registers: as listed in the register map.
- An asynchronous reset mid-window returns everything to these values immediately.

## Structure
- Register indices, reset constants and the state enum (CORE_PRIO, HWPE_PRIO) live in hci_package as hci_prio_sched_reg_e and hci_prio_sched_state_e.
- Sub-module hci_prio_sched_regfile holds the config decode and registers. The FSM and counters stay in the top.

## Test plan
- Reset -> all outputs 0; read CTRL = 0, HWPE_THR = 8, WINDOW = 64.
- auto_en = 1, HWPE_THR = 4, hwpe stalled continuously -> invert_prio_o rises on the cycle after the 4th stall cycle; SWITCH_CNT = 1.
- In HWPE_PRIO with WINDOW = 10 and no core stalls -> invert_prio_o is high for exactly 11 cycles, then falls.
- In HWPE_PRIO with CORE_THR = 3 and continuous core stalls -> invert_prio_o falls after 3 stall cycles, before the window expires.
- auto_en = 0, static_invert = 1, arb_policy = 2 -> invert_prio_o = 1 and arb_policy_o = 2 with no stall activity.
- Read index 7 -> rdata 0, opc 1, correct r_id; write index 5 while a switch occurs -> SWITCH_CNT reads 0.

Source files
------------

// File: rtl/hci_package.sv
// rtl/hci_package.sv - shared types and constants for the HCI priority scheduler
package hci_package;

  typedef enum logic [2:0] {
    REG_CTRL       = 3'd0,
    REG_HWPE_THR   = 3'd1,
    REG_CORE_THR   = 3'd2,
    REG_WINDOW     = 3'd3,
    REG_STATUS     = 3'd4,
    REG_SWITCH_CNT = 3'd5
  } hci_prio_sched_reg_e;

  typedef enum logic {
    CORE_PRIO = 1'b0,
    HWPE_PRIO = 1'b1
  } hci_prio_sched_state_e;

  localparam int unsigned PRIO_SCHED_THR_RST    = 8;
  localparam int unsigned PRIO_SCHED_WINDOW_RST = 64;

  // Expand per-byte enables into a per-bit write mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/hci_prio_sched_regfile.sv
// rtl/hci_prio_sched_regfile.sv - config decode, registers and response path
module hci_prio_sched_regfile
  import hci_package::*;
#(
  parameter int unsigned STALL_CNT_W = 8,
  parameter int unsigned WINDOW_W    = 16,
  parameter int unsigned ID_WIDTH    = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cfg_req_i,
  input  logic [31:0]            cfg_add_i,
  input  logic                   cfg_wen_i,
  input  logic [31:0]            cfg_wdata_i,
  input  logic [3:0]             cfg_be_i,
  input  logic [ID_WIDTH-1:0]    cfg_id_i,
  output logic                   cfg_gnt_o,
  output logic                   cfg_r_valid_o,
  output logic [31:0]            cfg_r_rdata_o,
  output logic                   cfg_r_opc_o,
  output logic [ID_WIDTH-1:0]    cfg_r_id_o,
  input  hci_prio_sched_state_e  state_i,
  input  logic [STALL_CNT_W-1:0] hwpe_cnt_i,
  input  logic [STALL_CNT_W-1:0] core_cnt_i,
  input  logic                   switch_inc_i,
  output logic                   auto_en_o,
  output logic                   static_invert_o,
  output logic [1:0]             arb_policy_o,
  output logic [7:0]             low_prio_max_stall_o,
  output logic [STALL_CNT_W-1:0] hwpe_thr_o,
  output logic [STALL_CNT_W-1:0] core_thr_o,
  output logic [WINDOW_W-1:0]    window_o
);

  logic [2:0]             idx;
  logic                   wr;
  logic                   rd;
  logic [31:0]            wmask;
  logic [11:0]            ctrl_q;
  logic [STALL_CNT_W-1:0] hwpe_thr_q;
  logic [STALL_CNT_W-1:0] core_thr_q;
  logic [WINDOW_W-1:0]    window_q;
  logic [31:0]            switch_cnt_q;
  logic [31:0]            rdata_d;
  logic                   opc_d;
  logic                   unused_bits;

  assign idx         = cfg_add_i[4:2];
  assign wr          = cfg_req_i & ~cfg_wen_i;
  assign rd          = cfg_req_i & cfg_wen_i;
  assign wmask       = be_mask(cfg_be_i);
  assign cfg_gnt_o   = cfg_req_i;
  assign unused_bits = ^{cfg_add_i[31:5], cfg_add_i[1:0], cfg_wdata_i, wmask};

  assign auto_en_o            = ctrl_q[0];
  assign static_invert_o      = ctrl_q[1];
  assign arb_policy_o         = ctrl_q[3:2];
  assign low_prio_max_stall_o = ctrl_q[11:4];
  assign hwpe_thr_o           = hwpe_thr_q;
  assign core_thr_o           = core_thr_q;
  assign window_o             = window_q;

  // Writable registers, merged byte by byte under the write mask.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q     <= '0;
      hwpe_thr_q <= STALL_CNT_W'(PRIO_SCHED_THR_RST);
      core_thr_q <= STALL_CNT_W'(PRIO_SCHED_THR_RST);
      window_q   <= WINDOW_W'(PRIO_SCHED_WINDOW_RST);
    end else if (wr) begin
      case (idx)
        REG_CTRL:
          ctrl_q <= (ctrl_q & ~wmask[11:0]) | (cfg_wdata_i[11:0] & wmask[11:0]);
        REG_HWPE_THR:
          hwpe_thr_q <= (hwpe_thr_q & ~wmask[STALL_CNT_W-1:0])
                      | (cfg_wdata_i[STALL_CNT_W-1:0] & wmask[STALL_CNT_W-1:0]);
        REG_CORE_THR:
          core_thr_q <= (core_thr_q & ~wmask[STALL_CNT_W-1:0])
                      | (cfg_wdata_i[STALL_CNT_W-1:0] & wmask[STALL_CNT_W-1:0]);
        REG_WINDOW:
          window_q <= (window_q & ~wmask[WINDOW_W-1:0])
                    | (cfg_wdata_i[WINDOW_W-1:0] & wmask[WINDOW_W-1:0]);
        default: ;
      endcase
    end
  end

  // Saturating switch counter; a write to its index clears it and beats a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      switch_cnt_q <= '0;
    end else if (wr && (idx == REG_SWITCH_CNT)) begin
      switch_cnt_q <= '0;
    end else if (switch_inc_i && (switch_cnt_q != '1)) begin
      switch_cnt_q <= switch_cnt_q + 32'd1;
    end
  end

  // Read mux and error flag for the current request.
  always_comb begin
    rdata_d = '0;
    opc_d   = 1'b0;
    case (idx)
      REG_CTRL:       rdata_d = 32'(ctrl_q);
      REG_HWPE_THR:   rdata_d = 32'(hwpe_thr_q);
      REG_CORE_THR:   rdata_d = 32'(core_thr_q);
      REG_WINDOW:     rdata_d = 32'(window_q);
      REG_STATUS: begin
        rdata_d[0]                = (state_i == HWPE_PRIO);
        rdata_d[8 +: STALL_CNT_W]  = hwpe_cnt_i;
        rdata_d[16 +: STALL_CNT_W] = core_cnt_i;
        opc_d                     = wr;
      end
      REG_SWITCH_CNT: rdata_d = switch_cnt_q;
      default:        opc_d   = 1'b1;
    endcase
    if (!rd) begin
      rdata_d = '0;
    end
  end

  // Response is returned exactly one cycle after each granted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_r_valid_o <= 1'b0;
      cfg_r_rdata_o <= '0;
      cfg_r_opc_o   <= 1'b0;
      cfg_r_id_o    <= '0;
    end else begin
      cfg_r_valid_o <= cfg_req_i;
      if (cfg_req_i) begin
        cfg_r_rdata_o <= rdata_d;
        cfg_r_opc_o   <= opc_d;
        cfg_r_id_o    <= cfg_id_i;
      end
    end
  end

endmodule

// File: rtl/hci_prio_scheduler.sv
// rtl/hci_prio_scheduler.sv - stall-driven priority switching for the TCDM interconnect
module hci_prio_scheduler
  import hci_package::*;
#(
  parameter int unsigned NB_CORES    = 8,
  parameter int unsigned NB_HWPE     = 1,
  parameter int unsigned STALL_CNT_W = 8,
  parameter int unsigned WINDOW_W    = 16,
  parameter int unsigned ID_WIDTH    = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NB_CORES-1:0] core_req_i,
  input  logic [NB_CORES-1:0] core_gnt_i,
  input  logic [NB_HWPE-1:0]  hwpe_req_i,
  input  logic [NB_HWPE-1:0]  hwpe_gnt_i,
  input  logic                cfg_req_i,
  input  logic [31:0]         cfg_add_i,
  input  logic                cfg_wen_i,
  input  logic [31:0]         cfg_wdata_i,
  input  logic [3:0]          cfg_be_i,
  input  logic [ID_WIDTH-1:0] cfg_id_i,
  output logic                cfg_gnt_o,
  output logic                cfg_r_valid_o,
  output logic [31:0]         cfg_r_rdata_o,
  output logic                cfg_r_opc_o,
  output logic [ID_WIDTH-1:0] cfg_r_id_o,
  output logic [1:0]          arb_policy_o,
  output logic                invert_prio_o,
  output logic [7:0]          low_prio_max_stall_o
);

  hci_prio_sched_state_e  state_q, state_d;
  logic [STALL_CNT_W-1:0] hwpe_cnt_q, hwpe_cnt_d, hwpe_cnt_inc;
  logic [STALL_CNT_W-1:0] core_cnt_q, core_cnt_d, core_cnt_inc;
  logic [STALL_CNT_W-1:0] hwpe_thr, core_thr, hwpe_thr_eff, core_thr_eff;
  logic [WINDOW_W-1:0]    window, win_q, win_d;
  logic                   auto_en, static_invert;
  logic                   hwpe_stall, core_stall, hwpe_gnt_any, core_gnt_any;
  logic                   switch_inc;

  hci_prio_sched_regfile #(
    .STALL_CNT_W (STALL_CNT_W),
    .WINDOW_W    (WINDOW_W),
    .ID_WIDTH    (ID_WIDTH)
  ) i_regfile (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .cfg_req_i            (cfg_req_i),
    .cfg_add_i            (cfg_add_i),
    .cfg_wen_i            (cfg_wen_i),
    .cfg_wdata_i          (cfg_wdata_i),
    .cfg_be_i             (cfg_be_i),
    .cfg_id_i             (cfg_id_i),
    .cfg_gnt_o            (cfg_gnt_o),
    .cfg_r_valid_o        (cfg_r_valid_o),
    .cfg_r_rdata_o        (cfg_r_rdata_o),
    .cfg_r_opc_o          (cfg_r_opc_o),
    .cfg_r_id_o           (cfg_r_id_o),
    .state_i              (state_q),
    .hwpe_cnt_i           (hwpe_cnt_q),
    .core_cnt_i           (core_cnt_q),
    .switch_inc_i         (switch_inc),
    .auto_en_o            (auto_en),
    .static_invert_o      (static_invert),
    .arb_policy_o         (arb_policy_o),
    .low_prio_max_stall_o (low_prio_max_stall_o),
    .hwpe_thr_o           (hwpe_thr),
    .core_thr_o           (core_thr),
    .window_o             (window)
  );

  assign hwpe_stall   = |(hwpe_req_i & ~hwpe_gnt_i);
  assign core_stall   = |(core_req_i & ~core_gnt_i);
  assign hwpe_gnt_any = |hwpe_gnt_i;
  assign core_gnt_any = |core_gnt_i;

  assign hwpe_cnt_inc = (hwpe_cnt_q == '1) ? hwpe_cnt_q : hwpe_cnt_q + STALL_CNT_W'(1);
  assign core_cnt_inc = (core_cnt_q == '1) ? core_cnt_q : core_cnt_q + STALL_CNT_W'(1);
  assign hwpe_thr_eff = (hwpe_thr == '0) ? STALL_CNT_W'(1) : hwpe_thr;
  assign core_thr_eff = (core_thr == '0) ? STALL_CNT_W'(1) : core_thr;

  // Output is a decode of registered state and CTRL only, so it has no input-to-output path.
  assign invert_prio_o = auto_en ? (state_q == HWPE_PRIO) : static_invert;

  // State, stall counters and window counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= CORE_PRIO;
      hwpe_cnt_q <= '0;
      core_cnt_q <= '0;
      win_q      <= '0;
    end else begin
      state_q    <= state_d;
      hwpe_cnt_q <= hwpe_cnt_d;
      core_cnt_q <= core_cnt_d;
      win_q      <= win_d;
    end
  end

  // Next-state logic: HWPE stalls open a priority window, core stalls or expiry close it.
  always_comb begin
    state_d    = state_q;
    hwpe_cnt_d = hwpe_cnt_q;
    core_cnt_d = core_cnt_q;
    win_d      = win_q;
    switch_inc = 1'b0;
    if (!auto_en) begin
      state_d    = CORE_PRIO;
      hwpe_cnt_d = '0;
      core_cnt_d = '0;
      win_d      = '0;
    end else begin
      case (state_q)
        CORE_PRIO: begin
          if (hwpe_stall) begin
            if (hwpe_cnt_inc >= hwpe_thr_eff) begin
              state_d    = HWPE_PRIO;
              win_d      = window;
              hwpe_cnt_d = '0;
              switch_inc = 1'b1;
            end else begin
              hwpe_cnt_d = hwpe_cnt_inc;
            end
          end else if (hwpe_gnt_any) begin
            hwpe_cnt_d = '0;
          end
        end
        HWPE_PRIO: begin
          if (win_q != '0) begin
            win_d = win_q - WINDOW_W'(1);
          end
          if (core_stall) begin
            core_cnt_d = core_cnt_inc;
          end else if (core_gnt_any) begin
            core_cnt_d = '0;
          end
          if ((win_q == '0) || (core_stall && (core_cnt_inc >= core_thr_eff))) begin
            state_d    = CORE_PRIO;
            hwpe_cnt_d = '0;
            core_cnt_d = '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hci_prio_scheduler.sv
// tb/tb_hci_prio_scheduler.sv - directed self-checking bench for hci_prio_scheduler
module tb_hci_prio_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  core_req, core_gnt;
  logic [0:0]  hwpe_req, hwpe_gnt;
  logic        cfg_req, cfg_wen;
  logic [31:0] cfg_add, cfg_wdata;
  logic [3:0]  cfg_be;
  logic [4:0]  cfg_id;
  logic        cfg_gnt, cfg_r_valid, cfg_r_opc;
  logic [31:0] cfg_r_rdata;
  logic [4:0]  cfg_r_id;
  logic [1:0]  arb_policy;
  logic        invert_prio;
  logic [7:0]  low_prio_max_stall;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rd;
  logic        op;
  logic [4:0]  rid;
  logic        rv;

  hci_prio_scheduler dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .core_req_i           (core_req),
    .core_gnt_i           (core_gnt),
    .hwpe_req_i           (hwpe_req),
    .hwpe_gnt_i           (hwpe_gnt),
    .cfg_req_i            (cfg_req),
    .cfg_add_i            (cfg_add),
    .cfg_wen_i            (cfg_wen),
    .cfg_wdata_i          (cfg_wdata),
    .cfg_be_i             (cfg_be),
    .cfg_id_i             (cfg_id),
    .cfg_gnt_o            (cfg_gnt),
    .cfg_r_valid_o        (cfg_r_valid),
    .cfg_r_rdata_o        (cfg_r_rdata),
    .cfg_r_opc_o          (cfg_r_opc),
    .cfg_r_id_o           (cfg_r_id),
    .arb_policy_o         (arb_policy),
    .invert_prio_o        (invert_prio),
    .low_prio_max_stall_o (low_prio_max_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [31:0] data,
                           input logic [3:0] be, output logic opc);
    cfg_req   = 1'b1;
    cfg_wen   = 1'b0;
    cfg_add   = {27'd0, idx, 2'b00};
    cfg_wdata = data;
    cfg_be    = be;
    cfg_id    = 5'd1;
    tick();
    cfg_req = 1'b0;
    opc     = cfg_r_opc;
  endtask

  task automatic cfg_read(input logic [2:0] idx, input logic [4:0] id, output logic [31:0] rdata,
                          output logic opc, output logic [4:0] r_id, output logic r_valid);
    cfg_req = 1'b1;
    cfg_wen = 1'b1;
    cfg_add = {27'd0, idx, 2'b00};
    cfg_id  = id;
    cfg_be  = 4'hf;
    tick();
    cfg_req = 1'b0;
    rdata   = cfg_r_rdata;
    opc     = cfg_r_opc;
    r_id    = cfg_r_id;
    r_valid = cfg_r_valid;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rst [6];
    exp_rst = '{32'd0, 32'd8, 32'd8, 32'd64, 32'd0, 32'd0};
    rst_n = 1'b0;
    core_req = '0; core_gnt = '0; hwpe_req = '0; hwpe_gnt = '0;
    cfg_req = 1'b0; cfg_wen = 1'b1; cfg_add = '0; cfg_wdata = '0; cfg_be = '0; cfg_id = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({invert_prio, arb_policy, low_prio_max_stall, cfg_r_valid} !== 12'd0) begin
      n_err++;
      $display("FAIL reset_outputs: inv=%b arb=%0d low=%h rvalid=%b required all 0",
               invert_prio, arb_policy, low_prio_max_stall, cfg_r_valid);
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      cfg_read(3'(i), 5'(i + 3), rd, op, rid, rv);
      n_cmp++;
      if (rd !== exp_rst[i] || op !== 1'b0 || rid !== 5'(i + 3) || rv !== 1'b1) begin
        n_err++;
        $display("FAIL reset_reg%0d: rdata=%h opc=%b id=%h valid=%b required rdata=%h opc=0 id=%h valid=1",
                 i, rd, op, rid, rv, exp_rst[i], 5'(i + 3));
      end
    end
  endtask

  task automatic test_grant_clear();
    cfg_write(3'd1, 32'd4, 4'hf, op);
    cfg_write(3'd2, 32'd200, 4'hf, op);
    cfg_write(3'd3, 32'd100, 4'hf, op);
    cfg_write(3'd0, 32'd1, 4'hf, op);
    hwpe_req = 1'b1; hwpe_gnt = 1'b0;
    repeat (3) tick();
    hwpe_gnt = 1'b1;
    tick();
    hwpe_gnt = 1'b0;
    repeat (3) tick();
    hwpe_req = 1'b0;
    n_cmp++;
    if (invert_prio !== 1'b0) begin
      n_err++;
      $display("FAIL grant_clear_inv: inv=%b required 0", invert_prio);
    end
    cfg_read(3'd4, 5'd2, rd, op, rid, rv);
    n_cmp++;
    if (rd !== 32'h0000_0300) begin
      n_err++;
      $display("FAIL grant_clear_status: got %h required 00000300", rd);
    end
    hwpe_req = 1'b1; hwpe_gnt = 1'b1;
    tick();
    hwpe_req = 1'b0; hwpe_gnt = 1'b0;
  endtask

  task automatic test_hwpe_switch();
    hwpe_req = 1'b1; hwpe_gnt = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++;
      if (invert_prio !== (k == 4)) begin
        n_err++;
        $display("FAIL hwpe_switch_stall%0d: inv=%b required %b", k, invert_prio, (k == 4));
      end
    end
    hwpe_req = 1'b0;
    cfg_read(3'd5, 5'd4, rd, op, rid, rv);
    n_cmp++;
    if (rd !== 32'd1) begin
      n_err++;
      $display("FAIL hwpe_switch_cnt: got %0d required 1", rd);
    end
    cfg_read(3'd4, 5'd5, rd, op, rid, rv);
    n_cmp++;
    if (rd !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL hwpe_switch_status: got %h required 00000001", rd);
    end
    cfg_write(3'd0, 32'd0, 4'hf, op);
    n_cmp++;
    if (invert_prio !== 1'b0) begin
      n_err++;
      $display("FAIL hwpe_switch_disable: inv=%b required 0", invert_prio);
    end
    tick();
  endtask

  task automatic test_window();
    int high;
    cfg_write(3'd3, 32'd10, 4'hf, op);
    cfg_write(3'd1, 32'd0, 4'hf, op);
    cfg_write(3'd0, 32'd1, 4'hf, op);
    hwpe_req = 1'b1; hwpe_gnt = 1'b0;
    tick();
    hwpe_req = 1'b0;
    high = 0;
    for (int i = 0; i < 40 && invert_prio === 1'b1; i++) begin
      high++;
      tick();
    end
    n_cmp++;
    if (high !== 11 || invert_prio !== 1'b0) begin
      n_err++;
      $display("FAIL window_length: high for %0d cycles inv=%b required 11 cycles then 0", high, invert_prio);
    end
    cfg_read(3'd5, 5'd6, rd, op, rid, rv);
    n_cmp++;
    if (rd !== 32'd2) begin
      n_err++;
      $display("FAIL window_switch_cnt: got %0d required 2", rd);
    end
  endtask

  task automatic test_core_stall();
    cfg_write(3'd2, 32'd3, 4'hf, op);
    cfg_write(3'd3, 32'd100, 4'hf, op);
    hwpe_req = 1'b1; hwpe_gnt = 1'b0;
    tick();
    hwpe_req = 1'b0;
    core_req = 8'h04; core_gnt = 8'h00;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++;
      if (invert_prio !== (k < 3)) begin
        n_err++;
        $display("FAIL core_stall%0d: inv=%b required %b", k, invert_prio, (k < 3));
      end
    end
    core_req = 8'h00;
    cfg_read(3'd4, 5'd7, rd, op, rid, rv);
    n_cmp++;
    if (rd !== 32'd0) begin
      n_err++;
      $display("FAIL core_stall_status: got %h required 00000000", rd);
    end
    cfg_read(3'd5, 5'd8, rd, op, rid, rv);
    n_cmp++;
    if (rd !== 32'd3) begin
      n_err++;
      $display("FAIL core_stall_switch_cnt: got %0d required 3", rd);
    end
  endtask

  task automatic test_clear_auto();
    hwpe_req = 1'b1; hwpe_gnt = 1'b0;
    tick();
    hwpe_req = 1'b0;
    cfg_write(3'd0, 32'd0, 4'hf, op);
    n_cmp++;
    if (invert_prio !== 1'b0) begin
      n_err++;
      $display("FAIL clear_auto_inv: inv=%b required 0", invert_prio);
    end
    tick();
    cfg_read(3'd4, 5'd9, rd, op, rid, rv);
    n_cmp++;
    if (rd !== 32'd0) begin
      n_err++;
      $display("FAIL clear_auto_status: got %h required 00000000", rd);
    end
  endtask

  task automatic test_static();
    cfg_write(3'd0, 32'h0000_0A5A, 4'hf, op);
    n_cmp++;
    if (invert_prio !== 1'b1 || arb_policy !== 2'd2 || low_prio_max_stall !== 8'hA5) begin
      n_err++;
      $display("FAIL static_outputs: inv=%b arb=%0d low=%h required inv=1 arb=2 low=a5",
               invert_prio, arb_policy, low_prio_max_stall);
    end
    hwpe_req = 1'b1; hwpe_gnt = 1'b0;
    repeat (5) tick();
    hwpe_req = 1'b0;
    cfg_read(3'd4, 5'd10, rd, op, rid, rv);
    n_cmp++;
    if (rd !== 32'd0 || invert_prio !== 1'b1) begin
      n_err++;
      $display("FAIL static_hold: status=%h inv=%b required status=00000000 inv=1", rd, invert_prio);
    end
    cfg_write(3'd0, 32'h0000_3C00, 4'b0010, op);
    n_cmp++;
    if (low_prio_max_stall !== 8'hC5 || arb_policy !== 2'd2) begin
      n_err++;
      $display("FAIL static_byte_en: low=%h arb=%0d required low=c5 arb=2", low_prio_max_stall, arb_policy);
    end
    cfg_read(3'd0, 5'd11, rd, op, rid, rv);
    n_cmp++;
    if (rd !== 32'h0000_0C5A) begin
      n_err++;
      $display("FAIL static_ctrl_read: got %h required 00000c5a", rd);
    end
  endtask

  task automatic test_bad_index();
    cfg_read(3'd7, 5'h13, rd, op, rid, rv);
    n_cmp++;
    if (rd !== 32'd0 || op !== 1'b1 || rid !== 5'h13 || rv !== 1'b1) begin
      n_err++;
      $display("FAIL bad_index_read7: rdata=%h opc=%b id=%h valid=%b required 0/1/13/1", rd, op, rid, rv);
    end
    cfg_read(3'd6, 5'h0c, rd, op, rid, rv);
    n_cmp++;
    if (rd !== 32'd0 || op !== 1'b1 || rid !== 5'h0c) begin
      n_err++;
      $display("FAIL bad_index_read6: rdata=%h opc=%b id=%h required 0/1/0c", rd, op, rid);
    end
    cfg_write(3'd4, 32'hffff_ffff, 4'hf, op);
    n_cmp++;
    if (op !== 1'b1) begin
      n_err++;
      $display("FAIL ro_status_write: opc=%b required 1", op);
    end
    cfg_write(3'd6, 32'hffff_ffff, 4'hf, op);
    n_cmp++;
    if (op !== 1'b1) begin
      n_err++;
      $display("FAIL bad_index_write6: opc=%b required 1", op);
    end
    cfg_write(3'd5, 32'd0, 4'hf, op);
    n_cmp++;
    if (op !== 1'b0) begin
      n_err++;
      $display("FAIL switch_clear_write: opc=%b required 0", op);
    end
    cfg_read(3'd0, 5'd14, rd, op, rid, rv);
    n_cmp++;
    if (rd !== 32'h0000_0C5A) begin
      n_err++;
      $display("FAIL bad_index_ctrl_intact: got %h required 00000c5a", rd);
    end
  endtask

  task automatic test_clear_collision();
    cfg_write(3'd0, 32'd1, 4'hf, op);
    hwpe_req = 1'b1; hwpe_gnt = 1'b0;
    tick();
    hwpe_req = 1'b0;
    cfg_write(3'd0, 32'd0, 4'hf, op);
    tick();
    cfg_write(3'd0, 32'd1, 4'hf, op);
    cfg_read(3'd5, 5'd15, rd, op, rid, rv);
    n_cmp++;
    if (rd !== 32'd1) begin
      n_err++;
      $display("FAIL collision_pre_cnt: got %0d required 1", rd);
    end
    cfg_req = 1'b1; cfg_wen = 1'b0; cfg_add = {27'd0, 3'd5, 2'b00}; cfg_wdata = 32'd0; cfg_be = 4'hf;
    hwpe_req = 1'b1; hwpe_gnt = 1'b0;
    tick();
    cfg_req = 1'b0;
    hwpe_req = 1'b0;
    n_cmp++;
    if (invert_prio !== 1'b1) begin
      n_err++;
      $display("FAIL collision_switch: inv=%b required 1", invert_prio);
    end
    cfg_read(3'd5, 5'd16, rd, op, rid, rv);
    n_cmp++;
    if (rd !== 32'd0) begin
      n_err++;
      $display("FAIL collision_cnt: got %0d required 0", rd);
    end
  endtask

  task automatic test_async_reset();
    cfg_write(3'd0, 32'h0000_000D, 4'hf, op);
    n_cmp++;
    if (invert_prio !== 1'b1 || arb_policy !== 2'd3) begin
      n_err++;
      $display("FAIL async_pre: inv=%b arb=%0d required inv=1 arb=3", invert_prio, arb_policy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (invert_prio !== 1'b0 || arb_policy !== 2'd0 || cfg_r_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_outputs: inv=%b arb=%0d rvalid=%b required all 0",
               invert_prio, arb_policy, cfg_r_valid);
    end
    tick();
    rst_n = 1'b1;
    tick();
    cfg_read(3'd1, 5'd17, rd, op, rid, rv);
    n_cmp++;
    if (rd !== 32'd8) begin
      n_err++;
      $display("FAIL async_hwpe_thr: got %0d required 8", rd);
    end
    cfg_read(3'd4, 5'd18, rd, op, rid, rv);
    n_cmp++;
    if (rd !== 32'd0) begin
      n_err++;
      $display("FAIL async_status: got %h required 00000000", rd);
    end
  endtask

  initial begin
    test_reset();
    test_grant_clear();
    test_hwpe_switch();
    test_window();
    test_core_stall();
    test_clear_auto();
    test_static();
    test_bad_index();
    test_clear_collision();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
